trace_buffer: RTL and testbench

- Per-row store of wall-trace results between the wall tracer (producer) and the row renderer (consumer).
- Tracer writes one {side, size, texu} record per screen row, sequentially.
- Display side reads the record for the current row with fixed 1-cycle latency and drives row_render inputs.
- Double-buffered: the display reads the front bank while the tracer fills the back bank; banks swap only at frame start.

---
 rtl/trace_buffer.sv | 148 ++++++++++++++
 tb/tb_trace_buffer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_buffer.sv
// Per-row wall-trace record store between the wall tracer and the row renderer.
// Define TRACE_BUFFER_DOUBLE_EN for front/back banking; the default build uses one shared bank.
module trace_buffer #(
    parameter int ROWS   = 480,
    parameter int SIZE_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic              wr_side,
    input  logic [SIZE_W-1:0] wr_size,
    input  logic [5:0]        wr_texu,
    input  logic [9:0]        rd_row,
    output logic              rd_side,
    output logic [SIZE_W-1:0] rd_size,
    output logic [5:0]        rd_texu,
    output logic              back_full,
    output logic              swapped
);
    localparam int PW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int WW = 1 + SIZE_W + 6;
    localparam logic [PW-1:0] LAST   = PW'(ROWS - 1);
    localparam logic [10:0]   ROWS_L = 11'(ROWS);

    typedef logic [WW-1:0] word_t;

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic              back_full_q, back_full_d;
    logic              front_valid_q, front_valid_d;
    logic              swapped_q, swapped_d;
    logic              rd_side_q;
    logic [SIZE_W-1:0] rd_size_q;
    logic [5:0]        rd_texu_q;

    logic              wr_fire;
    logic              rd_hit;
    logic [PW-1:0]     rd_idx;
    word_t             wr_word;
    word_t             rd_word;

    assign wr_fire = wr_valid && !back_full_q;
    assign wr_word = {wr_side, wr_size, wr_texu};
    assign rd_idx  = rd_row[PW-1:0];
    assign rd_hit  = front_valid_q && ({1'b0, rd_row} < ROWS_L);

    assign wr_ready  = !back_full_q;
    assign back_full = back_full_q;
    assign swapped   = swapped_q;
    assign rd_side   = rd_side_q;
    assign rd_size   = rd_size_q;
    assign rd_texu   = rd_texu_q;

`ifdef TRACE_BUFFER_DOUBLE_EN
    logic  front_q, front_d;
    word_t mem_q [2][ROWS];

    // Tracer always fills the bank that is not on screen.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[!front_q][wr_ptr_q] <= wr_word;
        end
    end

    assign rd_word = mem_q[front_q][rd_idx];
`else
    word_t mem_q [ROWS];

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= wr_word;
        end
    end

    assign rd_word = mem_q[rd_idx];
`endif

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        back_full_d   = back_full_q;
        front_valid_d = front_valid_q;
        swapped_d     = 1'b0;
`ifdef TRACE_BUFFER_DOUBLE_EN
        front_d       = front_q;
`endif
        if (wr_fire) begin
            if (wr_ptr_q == LAST) begin
                wr_ptr_d    = '0;
                back_full_d = 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
        end
`ifdef TRACE_BUFFER_DOUBLE_EN
        // Swap only on a complete back bank; wr_fire is idle then.
        if (frame_start && back_full_q) begin
            front_d       = !front_q;
            back_full_d   = 1'b0;
            front_valid_d = 1'b1;
            swapped_d     = 1'b1;
        end
`else
        front_valid_d = 1'b1;
        if (frame_start) begin
            wr_ptr_d    = '0;
            back_full_d = 1'b0;
            swapped_d   = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            back_full_q   <= 1'b0;
            front_valid_q <= 1'b0;
            swapped_q     <= 1'b0;
`ifdef TRACE_BUFFER_DOUBLE_EN
            front_q       <= 1'b0;
`endif
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            back_full_q   <= back_full_d;
            front_valid_q <= front_valid_d;
            swapped_q     <= swapped_d;
`ifdef TRACE_BUFFER_DOUBLE_EN
            front_q       <= front_d;
`endif
        end
    end

    // Out-of-range rows and an unpopulated front bank render as no wall.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_side_q <= 1'b0;
            rd_size_q <= '0;
            rd_texu_q <= '0;
        end else if (rd_hit) begin
            {rd_side_q, rd_size_q, rd_texu_q} <= rd_word;
        end else begin
            rd_side_q <= 1'b0;
            rd_size_q <= '0;
            rd_texu_q <= '0;
        end
    end

endmodule

// File: tb/tb_trace_buffer.sv
// Directed, table-driven bench for trace_buffer (480 rows, 11-bit size).
// Exercises TRACE_BUFFER_DOUBLE_EN behaviour when that macro is defined.
module tb_trace_buffer;
    localparam int ROWS   = 480;
    localparam int SIZE_W = 11;

    logic              clk = 1'b0;
    logic              reset;
    logic              frame_start;
    logic              wr_valid;
    logic              wr_ready;
    logic              wr_side;
    logic [SIZE_W-1:0] wr_size;
    logic [5:0]        wr_texu;
    logic [9:0]        rd_row;
    logic              rd_side;
    logic [SIZE_W-1:0] rd_size;
    logic [5:0]        rd_texu;
    logic              back_full;
    logic              swapped;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int row;
        int side;
        int size;
        int texu;
    } vec_t;

    vec_t tbl[6];

    trace_buffer #(.ROWS(ROWS), .SIZE_W(SIZE_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_start(frame_start),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_side    (wr_side),
        .wr_size    (wr_size),
        .wr_texu    (wr_texu),
        .rd_row     (rd_row),
        .rd_side    (rd_side),
        .rd_size    (rd_size),
        .rd_texu    (rd_texu),
        .back_full  (back_full),
        .swapped    (swapped)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Record pattern v for row r: {side, size, texu}.
    task automatic pat(input int v, input int r,
                       output logic s, output logic [SIZE_W-1:0] z,
                       output logic [5:0] t);
        logic [31:0] rr;
        rr = r;
        case (v)
            1: begin s = ~rr[0]; z = SIZE_W'(r + 1000); t = 6'(r + 1); end
            3: begin s = rr[0];  z = SIZE_W'(r + 500);  t = 6'(r);     end
            default: begin s = rr[0]; z = SIZE_W'(r); t = 6'(r); end
        endcase
    endtask

    task automatic fill(input int first, input int last, input int v,
                        input bit fs_last);
        for (int r = first; r <= last; r++) begin
            logic s;
            logic [SIZE_W-1:0] z;
            logic [5:0] t;
            pat(v, r, s, z, t);
            wr_valid = 1'b1;
            wr_side = s;
            wr_size = z;
            wr_texu = t;
            frame_start = fs_last && (r == last);
            if (r == first || r == last) chk("wr_ready_fill", int'(wr_ready), 1);
            tick();
        end
        wr_valid = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic write1(input int s, input int z, input int t);
        wr_valid = 1'b1;
        wr_side = s[0];
        wr_size = SIZE_W'(z);
        wr_texu = 6'(t);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic rd(input string nm, input int row,
                      input int s, input int z, input int t);
        rd_row = 10'(row);
        tick();
        chk({nm, "_side"}, int'(rd_side), s);
        chk({nm, "_size"}, int'(rd_size), z);
        chk({nm, "_texu"}, int'(rd_texu), t);
    endtask

    task automatic pulse_fs(input int exp_sw);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("swapped_pulse", int'(swapped), exp_sw);
    endtask

    task automatic run_table();
        for (int i = 0; i < 6; i++) begin
            rd_row = 10'(tbl[i].row);
            tick();
            chk($sformatf("tbl%0d_side", i), int'(rd_side), tbl[i].side);
            chk($sformatf("tbl%0d_size", i), int'(rd_size), tbl[i].size);
            chk($sformatf("tbl%0d_texu", i), int'(rd_texu), tbl[i].texu);
        end
    endtask

    task automatic hold_full(input int z);
        wr_valid = 1'b1;
        wr_side = 1'b0;
        wr_size = SIZE_W'(z);
        wr_texu = 6'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_wr_ready", int'(wr_ready), 0);
            chk("hold_back_full", int'(back_full), 1);
        end
    endtask

    initial begin
        tbl[0] = '{row: 0,    side: 0, size: 0,   texu: 0};
        tbl[1] = '{row: 1,    side: 1, size: 1,   texu: 1};
        tbl[2] = '{row: 100,  side: 0, size: 100, texu: 36};
        tbl[3] = '{row: 479,  side: 1, size: 479, texu: 31};
        tbl[4] = '{row: 480,  side: 0, size: 0,   texu: 0};
        tbl[5] = '{row: 1023, side: 0, size: 0,   texu: 0};

        reset = 1'b1;
        frame_start = 1'b0;
        wr_valid = 1'b0;
        wr_side = 1'b0;
        wr_size = '0;
        wr_texu = '0;
        rd_row = 10'd5;
        repeat (3) tick();
        chk("rst_rd_size", int'(rd_size), 0);
        chk("rst_rd_side", int'(rd_side), 0);
        chk("rst_rd_texu", int'(rd_texu), 0);
        chk("rst_wr_ready", int'(wr_ready), 1);
        chk("rst_back_full", int'(back_full), 0);
        chk("rst_swapped", int'(swapped), 0);
        reset = 1'b0;
        tick();
        chk("post_rst_rd_size", int'(rd_size), 0);

`ifdef TRACE_BUFFER_DOUBLE_EN
        fill(0, ROWS - 1, 0, 1'b0);
        chk("a_back_full", int'(back_full), 1);
        chk("a_wr_ready", int'(wr_ready), 0);
        rd("a_noswap", 10, 0, 0, 0);
        pulse_fs(1);
        chk("a_back_clr", int'(back_full), 0);
        tick();
        chk("a_swapped_end", int'(swapped), 0);
        run_table();

        fill(0, ROWS - 1, 1, 1'b1);
        tick();
        chk("b_no_swap", int'(swapped), 0);
        chk("b_back_full", int'(back_full), 1);
        rd("b_old", 10, 0, 10, 10);
        hold_full(2000);
        pulse_fs(1);
        tick();
        wr_valid = 1'b0;
        chk("b_back_pend", int'(back_full), 0);
        rd("b_new10", 10, 1, 1010, 11);
        rd("b_new0", 0, 1, 1000, 1);

        fill(1, 199, 3, 1'b0);
        pulse_fs(0);
        chk("c_back_full", int'(back_full), 0);
        rd("c_front", 10, 1, 1010, 11);
        fill(200, ROWS - 1, 3, 1'b0);
        chk("c_full", int'(back_full), 1);
        pulse_fs(1);
        rd("c_row0", 0, 0, 2000, 0);
        rd("c_row199", 199, 1, 699, 7);
        rd("c_row200", 200, 0, 700, 8);
        rd("c_row479", 479, 1, 979, 31);

        fill(0, 299, 0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("d_back_full", int'(back_full), 0);
        chk("d_wr_ready", int'(wr_ready), 1);
        chk("d_rd_size", int'(rd_size), 0);
        rd("d_nofront", 10, 0, 0, 0);
        rd("d_nofront2", 10, 0, 0, 0);
`else
        fill(0, 6, 0, 1'b0);
        write1(1, 55, 7);
        rd("s_row7", 7, 1, 55, 7);
        rd("s_row3", 3, 1, 3, 3);
        pulse_fs(1);
        tick();
        chk("s_swapped_end", int'(swapped), 0);

        fill(0, ROWS - 1, 0, 1'b0);
        chk("s_back_full", int'(back_full), 1);
        chk("s_wr_ready", int'(wr_ready), 0);
        hold_full(999);
        run_table();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("s_fs_swapped", int'(swapped), 1);
        chk("s_fs_ready", int'(wr_ready), 1);
        tick();
        wr_valid = 1'b0;
        chk("s_fs_swapped_end", int'(swapped), 0);
        rd("s_first_row0", 0, 0, 999, 0);
        rd("s_keep_row1", 1, 1, 1, 1);

        fill(1, 300, 0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("r_back_full", int'(back_full), 0);
        chk("r_wr_ready", int'(wr_ready), 1);
        chk("r_rd_size", int'(rd_size), 0);
        chk("r_swapped", int'(swapped), 0);
        rd("r_nofront", 10, 0, 0, 0);
        write1(0, 42, 9);
        rd("r_restart0", 0, 0, 42, 9);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
